// File: rtl/nap_ds_packet_arbiter.sv
// Purpose: packet-atomic round-robin merge of NUM_CH data-streaming sources onto one NAP tx stream.
// Latency: input accept -> o_out_valid 1 cycle; one IDLE arbitration bubble between packets.
// Backpressure: 2-entry skid; owner ready comes only from registered skid state, never from i_out_ready.
// Optional per-channel packet counters are enabled by defining ACX_NAP_DS_ARB_PKT_CNT_EN.

`ifndef ACX_NAP_VERTICAL_DATA_WIDTH
`define ACX_NAP_VERTICAL_DATA_WIDTH 293
`endif
`ifndef ACX_NAP_DS_ADDR_WIDTH
`define ACX_NAP_DS_ADDR_WIDTH 4
`endif

module nap_ds_packet_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = `ACX_NAP_VERTICAL_DATA_WIDTH,
  parameter int ADDR_WIDTH = `ACX_NAP_DS_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NUM_CH-1:0]            i_in_valid,
  input  logic [NUM_CH-1:0]            i_in_sop,
  input  logic [NUM_CH-1:0]            i_in_eop,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_in_data,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] i_in_addr,
  output logic [NUM_CH-1:0]            o_in_ready,
  output logic                         o_out_valid,
  output logic                         o_out_sop,
  output logic                         o_out_eop,
  output logic [DATA_WIDTH-1:0]        o_out_data,
  output logic [ADDR_WIDTH-1:0]        o_out_addr,
  input  logic                         i_out_ready,
  output logic [NUM_CH-1:0]            o_grant,
  output logic [NUM_CH*CNT_WIDTH-1:0]  o_pkt_count
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [NUM_CH-1:0] grant;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;

  beat_t             skid_mem [2];
  beat_t             in_beat;
  beat_t             head;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        skid_cnt;
  logic              out_stall;

  logic              owner_rdy;
  logic              in_fire;
  logic              in_last;
  logic              out_fire;

  // Round-robin search: first channel offering a sop at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int               idx;
      logic [PTR_W-1:0] sel;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = PTR_W'(idx);
      if (!win_found && i_in_valid[sel] && i_in_sop[sel]) begin
        win_found = 1'b1;
        win_idx   = sel;
      end
    end
  end

  // Beat presented by the current owner, plus the handshake qualifiers on it.
  always_comb begin
    in_beat.sop  = i_in_sop[owner];
    in_beat.eop  = i_in_eop[owner];
    in_beat.addr = i_in_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
    in_beat.data = i_in_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    // A stall seen last cycle with one entry held means the head is likely still stuck,
    // so hold off the source rather than depend on this cycle's i_out_ready.
    owner_rdy    = (state == LOCKED) &&
                   ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && !out_stall));
    in_fire      = owner_rdy && i_in_valid[owner];
    in_last      = in_fire && i_in_eop[owner];
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: lock on a winning sop, release once the owner's eop is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = LOCKED;
      LOCKED:  if (in_last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: only the owner ever sees ready, and only in LOCKED.
  always_comb begin
    o_in_ready        = '0;
    o_in_ready[owner] = owner_rdy;
  end

  // Grant, owner index and round-robin pointer bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if ((state == IDLE) && win_found) begin
      grant  <= NUM_CH'(1) << win_idx;
      owner  <= win_idx;
    end else if (in_last) begin
      grant  <= '0;
      rr_ptr <= (owner == LAST_CH) ? '0 : owner + PTR_W'(1);
    end
  end

  assign o_grant = grant;

  // Two-entry skid queue; the head entry drives the output port directly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      skid_cnt    <= 2'd0;
      out_stall   <= 1'b0;
    end else begin
      if (in_fire) begin
        skid_mem[wr_ptr] <= in_beat;
        wr_ptr           <= ~wr_ptr;
      end
      if (out_fire) rd_ptr <= ~rd_ptr;
      case ({in_fire, out_fire})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
      out_stall <= o_out_valid && !i_out_ready;
    end
  end

  // Output fields are forced to zero whenever nothing is offered.
  always_comb begin
    head        = skid_mem[rd_ptr];
    o_out_valid = (skid_cnt != 2'd0);
    out_fire    = o_out_valid && i_out_ready;
    o_out_sop   = o_out_valid && head.sop;
    o_out_eop   = o_out_valid && head.eop;
    o_out_data  = o_out_valid ? head.data : '0;
    o_out_addr  = o_out_valid ? head.addr : '0;
  end

`ifdef ACX_NAP_DS_ARB_PKT_CNT_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_pkt_cnt
    logic [CNT_WIDTH-1:0] cnt;

    // Count packets whose eop beat was accepted from this channel; wraps naturally.
    always_ff @(posedge i_clk) begin
      if (i_reset)                                cnt <= '0;
      else if (in_last && (owner == PTR_W'(c)))   cnt <= cnt + CNT_WIDTH'(1);
    end

    assign o_pkt_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`else
  assign o_pkt_count = '0;
`endif

endmodule

// File: tb/tb_nap_ds_packet_arbiter.sv
// Bench for nap_ds_packet_arbiter: directed packet scenarios on 4 channels.
// Sources are driven #1 after the rising edge; DUT outputs are sampled on the falling edge.
// Every output beat is logged with its cycle and compared to hand-derived order/timing.

module tb_nap_ds_packet_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 293;
  localparam int AW  = 4;
  localparam int CW  = 2;
`ifdef ACX_NAP_DS_ARB_PKT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_valid, in_sop, in_eop, in_ready;
  logic [NCH*DW-1:0] in_data;
  logic [NCH*AW-1:0] in_addr;
  logic              out_valid, out_sop, out_eop, out_ready;
  logic [DW-1:0]     out_data;
  logic [AW-1:0]     out_addr;
  logic [NCH-1:0]    grant;
  logic [NCH*CW-1:0] pkt_count;

  nap_ds_packet_arbiter #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_in_valid(in_valid), .i_in_sop(in_sop), .i_in_eop(in_eop),
    .i_in_data(in_data), .i_in_addr(in_addr), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_sop(out_sop), .o_out_eop(out_eop),
    .o_out_data(out_data), .o_out_addr(out_addr), .i_out_ready(out_ready),
    .o_grant(grant), .o_pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // source state per channel: packets to send, beats per packet, current packet/beat
  int np[NCH], bl[NCH], pi[NCH], bi[NCH];
  bit nosop0, toggle, watch_lock;
  int cyc;
  logic [NCH-1:0] last_g;

  logic [DW-1:0]  ob_data[$];
  logic           ob_sop[$];
  logic           ob_eop[$];
  logic [AW-1:0]  ob_addr[$];
  int             ob_cyc[$];
  logic [NCH-1:0] gh[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(int c, int p, int b);
    logic [DW-1:0] d;
    d = '0;
    d[15:0]     = 16'(c * 256 + p * 16 + b);
    d[150 -: 16] = 16'hC3A5 ^ 16'(b * 7 + c);
    d[DW-1 -: 8] = 8'(8'hA0 + c * 16 + p);
    return d;
  endfunction

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      logic v;
      v = (pi[c] < np[c]);
      in_valid[c] = v;
      in_sop[c]   = v && (bi[c] == 0);
      in_eop[c]   = v && (bi[c] == bl[c] - 1);
      in_data[c*DW +: DW] = v ? beat_data(c, pi[c], bi[c]) : '0;
      in_addr[c*AW +: AW] = AW'(c);
    end
    if (nosop0) begin
      in_valid[0] = 1'b1;
      in_sop[0]   = 1'b0;
      in_eop[0]   = 1'b0;
    end
  endtask

  task automatic set_src(input int c, input int beats, input int pkts, input int first);
    bl[c] = beats;
    np[c] = pkts;
    pi[c] = first;
    bi[c] = 0;
  endtask

  task automatic clear_rec();
    ob_data.delete(); ob_sop.delete(); ob_eop.delete();
    ob_addr.delete(); ob_cyc.delete(); gh.delete();
  endtask

  // one clock: sample handshakes at negedge, advance sources after posedge
  task automatic step();
    logic [NCH-1:0] acc;
    @(negedge clk);
    acc = in_valid & in_ready;
    if (in_ready != '0) check_eq("rdy_is_owner", in_ready, grant);
    if (watch_lock && grant[2]) check_eq("ch1_rdy_locked", in_ready[1], 1'b0);
    if (out_valid && out_ready) begin
      ob_data.push_back(out_data); ob_sop.push_back(out_sop);
      ob_eop.push_back(out_eop);   ob_addr.push_back(out_addr);
      ob_cyc.push_back(cyc);
    end
    if (grant !== last_g) begin
      if (grant != '0) gh.push_back(grant);
      last_g = grant;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c] && !(nosop0 && c == 0)) begin
        bi[c]++;
        if (bi[c] == bl[c]) begin
          bi[c] = 0;
          pi[c]++;
        end
      end
    end
    drive();
    if (toggle) out_ready = ~out_ready;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (ob_data.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, ob_data.size(), n);
  endtask

  task automatic check_beat(input int k, input int c, input int p, input int b, input int blen);
    if (k >= ob_data.size()) begin
      check_eq($sformatf("b%0d_present", k), ob_data.size(), k + 1);
      return;
    end
    check_eq($sformatf("b%0d_data", k), ob_data[k], beat_data(c, p, b));
    check_eq($sformatf("b%0d_sop", k),  ob_sop[k],  b == 0);
    check_eq($sformatf("b%0d_eop", k),  ob_eop[k],  b == blen - 1);
    check_eq($sformatf("b%0d_addr", k), ob_addr[k], AW'(c));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, out_valid, 1'b0);
    check_eq({tag, "_sop"},   out_sop,   1'b0);
    check_eq({tag, "_eop"},   out_eop,   1'b0);
    check_eq({tag, "_data"},  out_data,  '0);
    check_eq({tag, "_addr"},  out_addr,  '0);
    check_eq({tag, "_grant"}, grant,     '0);
    check_eq({tag, "_rdy"},   in_ready,  '0);
    check_eq({tag, "_cnt"},   pkt_count, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1; nosop0 = 1'b0; toggle = 1'b0; watch_lock = 1'b0;
    cyc = 0; last_g = '0;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_addr = '0;
    for (int c = 0; c < NCH; c++) set_src(c, 1, 0, 0);
    drive();
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;

    // idle after reset: nothing offered, nothing granted
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("idle_valid", out_valid, 1'b0);
      check_eq("idle_grant", grant, '0);
    end

    // all four channels offer a 3-beat packet together
    clear_rec();
    for (int c = 0; c < NCH; c++) set_src(c, 3, 1, 0);
    drive();
    wait_beats(12, 100, "rr4_beats");
    for (int k = 0; k < 12 && k < ob_data.size(); k++) begin
      check_beat(k, k / 3, 0, k % 3, 3);
      check_eq($sformatf("rr4_cyc%0d", k), ob_cyc[k] - ob_cyc[0], 4 * (k / 3) + (k % 3));
    end
    check_eq("rr4_ngrants", gh.size(), 4);
    for (int i = 0; i < 4 && i < gh.size(); i++)
      check_eq($sformatf("rr4_grant%0d", i), gh[i], NCH'(1) << i);
    repeat (3) step();

    // ch2 4-beat packet under toggling out_ready; ch1 arrives mid-packet
    clear_rec();
    for (int c = 0; c < NCH; c++) set_src(c, 1, 0, 0);
    set_src(2, 4, 1, 0);
    set_src(1, 2, 0, 0);
    toggle = 1'b1;
    drive();
    begin
      int k;
      k = 0;
      while (grant != 4'b0100 && k < 20) begin
        step();
        k++;
      end
      check_eq("bp_grant_ch2", grant, 4'b0100);
    end
    np[1] = 1;
    drive();
    watch_lock = 1'b1;
    wait_beats(6, 100, "bp_beats");
    watch_lock = 1'b0;
    repeat (4) step();
    toggle = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_no_dup", ob_data.size(), 6);
    for (int b = 0; b < 4; b++) check_beat(b, 2, 0, b, 4);
    for (int b = 0; b < 2; b++) check_beat(4 + b, 1, 0, b, 2);
    repeat (2) step();

    // ch3 back-to-back single-beat packets: one every 2 cycles
    clear_rec();
    set_src(3, 1, 4, 0);
    drive();
    wait_beats(4, 50, "sb_beats");
    for (int k = 0; k < 4 && k < ob_data.size(); k++) check_beat(k, 3, k, 0, 1);
    for (int k = 1; k < 4 && k < ob_cyc.size(); k++)
      check_eq($sformatf("sb_gap%0d", k), ob_cyc[k] - ob_cyc[k-1], 2);
    check_eq("sb_ngrants", gh.size(), 4);
    for (int i = 0; i < 4 && i < gh.size(); i++) check_eq("sb_grant", gh[i], 4'b1000);
    repeat (2) step();

    // pointer wrapped to 0 after ch3: ch0 beats ch1
    clear_rec();
    set_src(0, 1, 1, 0);
    set_src(1, 1, 1, 0);
    drive();
    wait_beats(2, 30, "wrap_beats");
    check_beat(0, 0, 0, 0, 1);
    check_beat(1, 1, 0, 0, 1);
    repeat (2) step();

    // reset in the middle of a 5-beat ch1 packet (pointer is 2 beforehand)
    clear_rec();
    set_src(1, 5, 1, 0);
    drive();
    wait_beats(2, 30, "mid_beats");
    np[1] = 0;
    drive();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    clear_rec();
    set_src(1, 5, 2, 1);
    set_src(2, 2, 1, 0);
    drive();
    wait_beats(7, 60, "post_beats");
    for (int b = 0; b < 5; b++) check_beat(b, 1, 1, b, 5);
    for (int b = 0; b < 2; b++) check_beat(5 + b, 2, 0, b, 2);
    repeat (2) step();

    // packet counters: ch0 sends 3 then 5 packets total with 2-bit counters
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("cnt_cleared", pkt_count, '0);
    clear_rec();
    set_src(0, 2, 3, 0);
    drive();
    wait_beats(6, 60, "cnt3_beats");
    repeat (3) step();
    check_eq("cnt_ch0_3", pkt_count[CW-1:0], CNT_EN ? 2'd3 : 2'd0);
    np[0] = 5;
    drive();
    wait_beats(10, 60, "cnt5_beats");
    repeat (3) step();
    check_eq("cnt_ch0_5", pkt_count[CW-1:0], CNT_EN ? 2'd1 : 2'd0);
    check_eq("cnt_others", pkt_count[NCH*CW-1:CW], '0);

    // valid without sop while idle is never a request
    clear_rec();
    nosop0 = 1'b1;
    drive();
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("nosop_grant", grant, '0);
      check_eq("nosop_rdy", in_ready, '0);
      check_eq("nosop_valid", out_valid, 1'b0);
    end
    nosop0 = 1'b0;
    drive();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
